saxi_mem_slave: RTL

Synthesizable memory-backed slave for the simplified AXI (SAXI) interface, sitting directly downstream of `axi_master` and replacing the behavioural `axi_slave` as the DUT. It buffers independent write-address, write-data and read-address requests, pairs AW with W in arrival order, and commits writes to an internal word memory. It issues one write response per committed write and returns read data tagged with the request ID after a fixed latency.

---
 rtl/axi_transaction.sv | 8 +
 rtl/saxi_mem_slave_pkg.sv | 10 +
 rtl/saxi_fifo.sv | 48 ++++
 rtl/saxi_mem_slave.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/axi_transaction.sv
// Shared SAXI transaction types used by the master, the slaves and their benches.
package axi_transaction;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  id_t;

endpackage

// File: rtl/saxi_mem_slave_pkg.sv
// Block-local types for the memory-backed SAXI slave.
package saxi_mem_slave_pkg;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_WAIT  = 2'd1,
        R_VALID = 2'd2
    } r_state_t;

endpackage

// File: rtl/saxi_fifo.sv
// Registered, non-fall-through FIFO: an entry pushed on one edge is poppable on the next.
module saxi_fifo #(
    parameter type T     = logic [31:0],
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     din,
    input  logic pop,
    output logic full,
    output logic empty,
    output T     dout
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0] wr_ptr_q;
    logic [PW:0] rd_ptr_q;
    T            mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign dout  = mem_q[rd_ptr_q[PW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= din;
    end

endmodule

// File: rtl/saxi_mem_slave.sv
// Memory-backed SAXI slave: queues AW/W/AR, pairs AW with W in order, serves reads one at a time.
//   state   | meaning
//   R_IDLE  | waiting for a queued read address
//   R_WAIT  | latency countdown, memory captured when it reaches zero
//   R_VALID | rdata/rid presented until rready
module saxi_mem_slave
    import axi_transaction::*;
    import saxi_mem_slave_pkg::*;
#(
    parameter int AW_DEPTH     = 4,
    parameter int W_DEPTH      = 4,
    parameter int AR_DEPTH     = 4,
    parameter int MEM_WORDS    = 256,
    parameter int READ_LATENCY = 2,
    parameter int B_MAX        = 7
) (
    input  logic  clk,
    input  logic  rst,
    input  addr_t awaddr,
    input  logic  awvalid,
    output logic  awready,
    input  data_t wdata,
    input  logic  wvalid,
    output logic  wready,
    output logic  bvalid,
    input  logic  bready,
    input  addr_t araddr,
    input  id_t   arid,
    input  logic  arvalid,
    output logic  arready,
    output data_t rdata,
    output id_t   rid,
    output logic  rvalid,
    input  logic  rready
);

    localparam int IW     = $clog2(MEM_WORDS);
    localparam int BW     = $clog2(B_MAX + 1);
    localparam int CW     = $clog2(READ_LATENCY + 1);
    localparam int AW_MSB = $bits(addr_t) - 1;

    typedef logic [IW-1:0] mem_index_t;

    typedef struct packed {
        mem_index_t idx;
        id_t        id;
    } ar_entry_t;

    logic       ready_en_q;
    logic       aw_full, aw_empty, w_full, w_empty, ar_full, ar_empty;
    logic       aw_push, w_push, ar_push, ar_pop;
    addr_t      aw_dout;
    data_t      w_dout;
    ar_entry_t  ar_din, ar_dout;
    mem_index_t aw_idx;

    logic          commit, b_hs;
    logic [BW-1:0] bcnt_q, bcnt_d;

    r_state_t      r_state_q, r_state_d;
    logic [CW-1:0] r_cnt_q, r_cnt_d;
    mem_index_t    rd_idx_q, rd_idx_d;
    id_t           rid_q, rid_d;
    data_t         rdata_q, rdata_d;

    data_t mem_q [MEM_WORDS];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{aw_dout[AW_MSB:IW+2], aw_dout[1:0],
                                araddr[AW_MSB:IW+2], araddr[1:0]};

    // Ready is held low through reset and comes up on the first edge after release.
    assign awready = ready_en_q && !aw_full;
    assign wready  = ready_en_q && !w_full;
    assign arready = ready_en_q && !ar_full;

    assign aw_push = awvalid && awready;
    assign w_push  = wvalid && wready;
    assign ar_push = arvalid && arready;

    assign ar_din.idx = araddr[IW+1:2];
    assign ar_din.id  = arid;
    assign aw_idx     = aw_dout[IW+1:2];

    saxi_fifo #(.T(addr_t), .DEPTH(AW_DEPTH)) u_aw_fifo (
        .clk(clk), .rst(rst), .push(aw_push), .din(awaddr), .pop(commit),
        .full(aw_full), .empty(aw_empty), .dout(aw_dout)
    );

    saxi_fifo #(.T(data_t), .DEPTH(W_DEPTH)) u_w_fifo (
        .clk(clk), .rst(rst), .push(w_push), .din(wdata), .pop(commit),
        .full(w_full), .empty(w_empty), .dout(w_dout)
    );

    saxi_fifo #(.T(ar_entry_t), .DEPTH(AR_DEPTH)) u_ar_fifo (
        .clk(clk), .rst(rst), .push(ar_push), .din(ar_din), .pop(ar_pop),
        .full(ar_full), .empty(ar_empty), .dout(ar_dout)
    );

    assign bvalid = (bcnt_q != '0);
    assign b_hs   = bvalid && bready;
    // A response leaving this cycle frees a slot for the commit on the same edge.
    assign commit = !aw_empty && !w_empty && ((bcnt_q < BW'(B_MAX)) || b_hs);

    always_comb begin
        bcnt_d = bcnt_q;
        if (commit && !b_hs)      bcnt_d = bcnt_q + 1'b1;
        else if (!commit && b_hs) bcnt_d = bcnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (commit) mem_q[aw_idx] <= w_dout;
    end

    always_comb begin
        r_state_d = r_state_q;
        r_cnt_d   = r_cnt_q;
        rd_idx_d  = rd_idx_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        ar_pop    = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                if (!ar_empty) begin
                    ar_pop    = 1'b1;
                    rd_idx_d  = ar_dout.idx;
                    rid_d     = ar_dout.id;
                    r_cnt_d   = CW'(READ_LATENCY - 1);
                    r_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (r_cnt_q == '0) begin
                    // Write-first: a commit to the same word on this edge is returned.
                    rdata_d   = (commit && (aw_idx == rd_idx_q)) ? w_dout : mem_q[rd_idx_q];
                    r_state_d = R_VALID;
                end else begin
                    r_cnt_d = r_cnt_q - 1'b1;
                end
            end
            R_VALID: begin
                if (rready) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    assign rvalid = (r_state_q == R_VALID);
    assign rdata  = rdata_q;
    assign rid    = rid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_en_q <= 1'b0;
            bcnt_q     <= '0;
            r_state_q  <= R_IDLE;
            r_cnt_q    <= '0;
            rd_idx_q   <= '0;
            rid_q      <= '0;
            rdata_q    <= '0;
        end else begin
            ready_en_q <= 1'b1;
            bcnt_q     <= bcnt_d;
            r_state_q  <= r_state_d;
            r_cnt_q    <= r_cnt_d;
            rd_idx_q   <= rd_idx_d;
            rid_q      <= rid_d;
            rdata_q    <= rdata_d;
        end
    end

endmodule
